// File: rtl/auto_motion_executor.sv
// Auto-mode motion executor: timed, mutually exclusive drive outputs and barrier pulses.
// Build option AUTO_SETTLE_EN adds a post-turn SETTLE state with its own counter.
module auto_motion_executor #(
    parameter int unsigned TURN_90_CYCLES       = 90_000_000,
    parameter int unsigned BARRIER_PULSE_CYCLES = 10,
    parameter int unsigned SETTLE_CYCLES        = 20_000_000,
    parameter int unsigned CNT_W                = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic move_forward,
    input  logic trigger_turn_left,
    input  logic trigger_turn_right,
    input  logic trigger_turn_back,
    input  logic place_barrier_signal,
    input  logic destroy_barrier_signal,
    output logic forward_drive,
    output logic turn_left_drive,
    output logic turn_right_drive,
    output logic place_barrier,
    output logic destroy_barrier,
    output logic moving,
    output logic is_turning
);

    localparam int unsigned PW = $clog2(BARRIER_PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_90_CYCLES - 1);
    localparam logic [CNT_W-1:0] UTURN_LD = CNT_W'(2 * TURN_90_CYCLES - 1);
    localparam logic [PW-1:0]    PULSE_LD = PW'(BARRIER_PULSE_CYCLES - 1);

    if (TURN_90_CYCLES == 0 || BARRIER_PULSE_CYCLES == 0 || SETTLE_CYCLES == 0 ||
        (((2 * 64'(TURN_90_CYCLES)) - 64'd1) >> CNT_W) != 64'd0) begin : g_bad_cfg
        $error("auto_motion_executor: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        FORWARD,
        TURN_L,
        TURN_R,
        TURN_B
`ifdef AUTO_SETTLE_EN
        , SETTLE
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d;
`ifdef AUTO_SETTLE_EN
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
`endif

    logic          place_prev_q, destroy_prev_q;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          place_q, place_d;
    logic          destroy_q, destroy_d;

    logic fwd_q, fwd_d;
    logic tl_q, tl_d;
    logic tr_q, tr_d;
    logic turning_q, turning_d;
    logic moving_q, moving_d;

    logic place_edge, destroy_edge, arb_state, pulse_active;

    assign place_edge   = place_barrier_signal & ~place_prev_q;
    assign destroy_edge = destroy_barrier_signal & ~destroy_prev_q;
    assign arb_state    = (state_q == IDLE) || (state_q == FORWARD);
    assign pulse_active = place_q | destroy_q;

    // State register, counters, edge detectors and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            turn_cnt_q     <= '0;
`ifdef AUTO_SETTLE_EN
            settle_cnt_q   <= '0;
`endif
            place_prev_q   <= 1'b0;
            destroy_prev_q <= 1'b0;
            pulse_cnt_q    <= '0;
            place_q        <= 1'b0;
            destroy_q      <= 1'b0;
            fwd_q          <= 1'b0;
            tl_q           <= 1'b0;
            tr_q           <= 1'b0;
            turning_q      <= 1'b0;
            moving_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            turn_cnt_q     <= turn_cnt_d;
`ifdef AUTO_SETTLE_EN
            settle_cnt_q   <= settle_cnt_d;
`endif
            place_prev_q   <= place_barrier_signal;
            destroy_prev_q <= destroy_barrier_signal;
            pulse_cnt_q    <= pulse_cnt_d;
            place_q        <= place_d;
            destroy_q      <= destroy_d;
            fwd_q          <= fwd_d;
            tl_q           <= tl_d;
            tr_q           <= tr_d;
            turning_q      <= turning_d;
            moving_q       <= moving_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
`ifdef AUTO_SETTLE_EN
        settle_cnt_d = settle_cnt_q;
`endif
        if (!enable) begin
            state_d    = IDLE;
            turn_cnt_d = '0;
`ifdef AUTO_SETTLE_EN
            settle_cnt_d = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE, FORWARD: begin
                    if (trigger_turn_back) begin
                        state_d    = TURN_B;
                        turn_cnt_d = UTURN_LD;
                    end else if (trigger_turn_left) begin
                        state_d    = TURN_L;
                        turn_cnt_d = TURN_LD;
                    end else if (trigger_turn_right) begin
                        state_d    = TURN_R;
                        turn_cnt_d = TURN_LD;
                    end else begin
                        state_d = move_forward ? FORWARD : IDLE;
                    end
                end
                TURN_L, TURN_R, TURN_B: begin
                    if (turn_cnt_q == '0) begin
`ifdef AUTO_SETTLE_EN
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LD;
`else
                        state_d      = IDLE;
`endif
                    end else begin
                        turn_cnt_d = turn_cnt_q - CNT_W'(1);
                    end
                end
`ifdef AUTO_SETTLE_EN
                SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SW'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Place beats destroy on a same-cycle edge; edges during a pulse or turn are dropped
    always_comb begin
        place_d     = place_q;
        destroy_d   = destroy_q;
        pulse_cnt_d = pulse_cnt_q;
        if (!enable) begin
            place_d     = 1'b0;
            destroy_d   = 1'b0;
            pulse_cnt_d = '0;
        end else if (pulse_active) begin
            if (pulse_cnt_q == '0) begin
                place_d   = 1'b0;
                destroy_d = 1'b0;
            end else begin
                pulse_cnt_d = pulse_cnt_q - PW'(1);
            end
        end else if (arb_state && place_edge) begin
            place_d     = 1'b1;
            pulse_cnt_d = PULSE_LD;
        end else if (arb_state && destroy_edge) begin
            destroy_d   = 1'b1;
            pulse_cnt_d = PULSE_LD;
        end
    end

    always_comb begin
        fwd_d     = (state_d == FORWARD);
        tl_d      = (state_d == TURN_L);
        tr_d      = (state_d == TURN_R) || (state_d == TURN_B);
        turning_d = (state_d == TURN_L) || (state_d == TURN_R) ||
                    (state_d == TURN_B);
`ifdef AUTO_SETTLE_EN
        turning_d = turning_d || (state_d == SETTLE);
`endif
        moving_d  = fwd_d || turning_d;
    end

    assign forward_drive    = fwd_q;
    assign turn_left_drive  = tl_q;
    assign turn_right_drive = tr_q;
    assign place_barrier    = place_q;
    assign destroy_barrier  = destroy_q;
    assign moving           = moving_q;
    assign is_turning       = turning_q;

endmodule

// File: tb/tb_auto_motion_executor.sv
// Directed bench for auto_motion_executor (TURN=8, PULSE=3, SETTLE=4).
// Output vector order: fwd, left, right, place, destroy, moving, turning.
module tb_auto_motion_executor;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic move_forward;
    logic trigger_turn_left;
    logic trigger_turn_right;
    logic trigger_turn_back;
    logic place_barrier_signal;
    logic destroy_barrier_signal;
    logic forward_drive;
    logic turn_left_drive;
    logic turn_right_drive;
    logic place_barrier;
    logic destroy_barrier;
    logic moving;
    logic is_turning;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] O_IDLE = 7'b000_00_00;
    localparam logic [6:0] O_FWD  = 7'b100_00_10;
    localparam logic [6:0] O_TL   = 7'b010_00_11;
    localparam logic [6:0] O_TR   = 7'b001_00_11;
    localparam logic [6:0] O_FWDP = 7'b100_10_10;
    localparam logic [6:0] O_FWDD = 7'b100_01_10;

    logic [6:0] outs;
    assign outs = {forward_drive, turn_left_drive, turn_right_drive,
                   place_barrier, destroy_barrier, moving, is_turning};

    always #5 clk = ~clk;

    auto_motion_executor #(
        .TURN_90_CYCLES(8),
        .BARRIER_PULSE_CYCLES(3),
        .SETTLE_CYCLES(4),
        .CNT_W(28)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .move_forward(move_forward),
        .trigger_turn_left(trigger_turn_left),
        .trigger_turn_right(trigger_turn_right),
        .trigger_turn_back(trigger_turn_back),
        .place_barrier_signal(place_barrier_signal),
        .destroy_barrier_signal(destroy_barrier_signal),
        .forward_drive(forward_drive),
        .turn_left_drive(turn_left_drive),
        .turn_right_drive(turn_right_drive),
        .place_barrier(place_barrier),
        .destroy_barrier(destroy_barrier),
        .moving(moving),
        .is_turning(is_turning)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        move_forward = 1'b0;
        trigger_turn_left = 1'b0;
        trigger_turn_right = 1'b0;
        trigger_turn_back = 1'b0;
        place_barrier_signal = 1'b0;
        destroy_barrier_signal = 1'b0;
        tick();
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_state got %b want %b", outs, O_IDLE);
        end
    endtask

    task automatic test_forward();
        rst = 1'b0;
        enable = 1'b1;
        move_forward = 1'b1;
        tick();
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL forward_start got %b want %b", outs, O_FWD);
        end
    endtask

    task automatic test_turn_left();
        trigger_turn_left = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs !== O_TL) begin
                errors++;
                $display("FAIL turn_left_cyc%0d got %b want %b", i, outs, O_TL);
            end
            tick();
        end
`ifdef AUTO_SETTLE_EN
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (outs !== 7'b000_00_11) begin
                errors++;
                $display("FAIL settle_cyc%0d got %b want %b", s, outs, 7'b000_00_11);
            end
            tick();
        end
`endif
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL turn_left_end got %b want %b", outs, O_IDLE);
        end
        tick();
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL turn_left_resume got %b want %b", outs, O_FWD);
        end
    endtask

    task automatic test_uturn();
        trigger_turn_back = 1'b1;
        trigger_turn_right = 1'b1;
        tick();
        trigger_turn_back = 1'b0;
        trigger_turn_right = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (outs !== O_TR) begin
                errors++;
                $display("FAIL uturn_cyc%0d got %b want %b", i, outs, O_TR);
            end
            trigger_turn_left = (i == 5);
            tick();
        end
        trigger_turn_left = 1'b0;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL uturn_end got %b want %b", outs, O_IDLE);
        end
        tick();
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL uturn_resume got %b want %b", outs, O_FWD);
        end
    endtask

    task automatic test_barrier();
        place_barrier_signal = 1'b1;
        destroy_barrier_signal = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs !== O_FWDP) begin
                errors++;
                $display("FAIL place_pulse_cyc%0d got %b want %b", i, outs, O_FWDP);
            end
            tick();
        end
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL place_pulse_end got %b want %b", outs, O_FWD);
        end
        place_barrier_signal = 1'b0;
        destroy_barrier_signal = 1'b0;
        tick();
        destroy_barrier_signal = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs !== O_FWDD) begin
                errors++;
                $display("FAIL destroy_pulse_cyc%0d got %b want %b", i, outs, O_FWDD);
            end
            if (i == 0) place_barrier_signal = 1'b1;
            tick();
        end
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL edge_in_pulse got %b want %b", outs, O_FWD);
        end
        place_barrier_signal = 1'b0;
        destroy_barrier_signal = 1'b0;
        tick();
    endtask

    task automatic test_barrier_in_turn();
        trigger_turn_right = 1'b1;
        tick();
        trigger_turn_right = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs !== O_TR) begin
                errors++;
                $display("FAIL turn_right_cyc%0d got %b want %b", i, outs, O_TR);
            end
            if (i == 1) place_barrier_signal = 1'b1;
            tick();
        end
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL turn_right_end got %b want %b", outs, O_IDLE);
        end
        tick();
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL place_in_turn got %b want %b", outs, O_FWD);
        end
        place_barrier_signal = 1'b0;
        tick();
    endtask

    task automatic test_enable_abort();
        trigger_turn_left = 1'b1;
        trigger_turn_right = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        trigger_turn_right = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (outs !== O_TL) begin
                errors++;
                $display("FAIL left_over_right_cyc%0d got %b want %b", i, outs, O_TL);
            end
        end
        enable = 1'b0;
        place_barrier_signal = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL enable_abort got %b want %b", outs, O_IDLE);
        end
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL enable_hold got %b want %b", outs, O_IDLE);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL enable_resume got %b want %b", outs, O_FWD);
        end
        tick();
        checks++;
        if (outs !== O_FWD) begin
            errors++;
            $display("FAIL stale_level_no_pulse got %b want %b", outs, O_FWD);
        end
        place_barrier_signal = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_turn();
        trigger_turn_left = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (outs !== O_TL) begin
                errors++;
                $display("FAIL pre_reset_cyc%0d got %b want %b", i, outs, O_TL);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL async_reset got %b want %b", outs, O_IDLE);
        end
        tick();
        rst = 1'b0;
        move_forward = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset_idle got %b want %b", outs, O_IDLE);
        end
        trigger_turn_left = 1'b1;
        tick();
        trigger_turn_left = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs !== O_TL) begin
                errors++;
                $display("FAIL post_reset_turn_cyc%0d got %b want %b", i, outs, O_TL);
            end
            tick();
        end
`ifdef AUTO_SETTLE_EN
        repeat (4) tick();
`endif
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset_turn_end got %b want %b", outs, O_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_turn_left();
`ifndef AUTO_SETTLE_EN
        test_uturn();
        test_barrier();
        test_barrier_in_turn();
        test_enable_abort();
`endif
        test_reset_mid_turn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
